// File: rtl/simulador_planta_vinho_pkg.sv
// Shared types for the wine-bottling plant model: line-position states and error-flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkg_planta_vinho;

    typedef enum logic [1:0] {
        S_TRANSP_ENCH = 2'd0,
        S_ENCH        = 2'd1,
        S_TRANSP_CQ   = 2'd2,
        S_CQ          = 2'd3
    } estado_t;

    localparam int ERR_VALVULA           = 0;
    localparam int ERR_SAIDA_REPROVADA   = 1;
    localparam int ERR_DESCARTE_APROVADA = 2;

    localparam int CNT_W = 8;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] inc_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/simulador_planta_vinho_temporizador_sat.sv
// Saturating up-counter with clear priority, a "at limit" flag and a "will be at limit after this edge" flag.
// Latency: count updates one cycle after en/clr; done follows the count register.
// Backpressure: none; counting simply stops at MAX until cleared.
module temporizador_sat #(
    parameter int W   = 8,
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done,
    output logic done_prox
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] PRE_V = W'(MAX - 1);

    logic [W-1:0] cnt;

    // Clear wins over enable; the count holds once it reaches MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done      = (cnt == MAX_V);
    // Ignores clr on purpose: callers only look at it when no clear is pending.
    assign done_prox = done || (en && (cnt == PRE_V));

endmodule

// File: rtl/simulador_planta_vinho.sv
// Plant model of the bottling line: turns actuator commands into sensor/QC responses, counts bottles, flags misuse.
// Latency: every output is a flop that reacts one cycle after the input that caused it.
// Backpressure: none; with all commands low the line holds its position indefinitely.
module simulador_planta_vinho
    import pkg_planta_vinho::*;
#(
    parameter int T_TRANSPORTE = 8,
    parameter int T_ENCHER     = 5,
    parameter int T_VEDAR      = 3,
    parameter int T_INSPECAO   = 4,
    parameter int REPROVA_CADA = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       esteira,
    input  logic       valvula_ativa,
    input  logic       vedacao_ativa,
    input  logic       descarte_ativo,
    output logic       sensor_posicao_enchimento,
    output logic       sensor_nivel,
    output logic       sensor_posicao_cq,
    output logic       aprovado,
    output logic       reprovado,
    output logic [7:0] garrafas_ok,
    output logic [7:0] garrafas_descartadas,
    output logic [2:0] erro
);

    // Divisor kept non-zero so the modulo below is always legal; forced failures are gated separately.
    localparam int RC_DIV = (REPROVA_CADA == 0) ? 1 : REPROVA_CADA;

    estado_t    estado;
    logic [7:0] idx;

    logic em_transporte, chega_ench, chega_cq;
    logic pos_done, cheia, nivel_prox, vedada, insp_prox;
    logic forca_reprova, reprova;
    logic unused_pos_prox, unused_seal_prox, unused_insp_done;

    assign em_transporte = (estado == S_TRANSP_ENCH) || (estado == S_TRANSP_CQ);
    assign chega_ench    = (estado == S_TRANSP_ENCH) && esteira && pos_done;
    assign chega_cq      = (estado == S_TRANSP_CQ) && esteira && pos_done;

    // Position counter tops out at T_TRANSPORTE-1: the next motor cycle completes the move.
    temporizador_sat #(.W(CNT_W), .MAX(T_TRANSPORTE - 1)) u_pos (
        .clk(clk), .reset(reset), .clr(chega_ench || chega_cq),
        .en(em_transporte && esteira), .done(pos_done), .done_prox(unused_pos_prox)
    );

    // Fill level; "cheia" is simply the saturated state and stays until the next bottle arrives.
    temporizador_sat #(.W(CNT_W), .MAX(T_ENCHER)) u_fill (
        .clk(clk), .reset(reset), .clr(chega_ench),
        .en((estado == S_ENCH) && valvula_ativa), .done(cheia), .done_prox(nivel_prox)
    );

    // Sealing only makes progress on a bottle that is already full.
    temporizador_sat #(.W(CNT_W), .MAX(T_VEDAR)) u_seal (
        .clk(clk), .reset(reset), .clr(chega_ench),
        .en((estado == S_ENCH) && vedacao_ativa && cheia), .done(vedada), .done_prox(unused_seal_prox)
    );

    // Inspection timer runs freely while a bottle sits at QC.
    temporizador_sat #(.W(CNT_W), .MAX(T_INSPECAO)) u_insp (
        .clk(clk), .reset(reset), .clr(chega_cq),
        .en(estado == S_CQ), .done(unused_insp_done), .done_prox(insp_prox)
    );

    assign forca_reprova = (REPROVA_CADA != 0) && ((int'(idx) % RC_DIV) == 0);
    assign reprova       = !cheia || !vedada || forca_reprova;

    // Line FSM plus every registered output, counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado                    <= S_TRANSP_ENCH;
            idx                       <= '0;
            sensor_posicao_enchimento <= 1'b0;
            sensor_nivel              <= 1'b0;
            sensor_posicao_cq         <= 1'b0;
            aprovado                  <= 1'b0;
            reprovado                 <= 1'b0;
            garrafas_ok               <= '0;
            garrafas_descartadas      <= '0;
            erro                      <= '0;
        end else begin
            if (valvula_ativa && ((estado != S_ENCH) || esteira)) begin
                erro[ERR_VALVULA] <= 1'b1;
            end
            case (estado)
                S_TRANSP_ENCH: begin
                    if (chega_ench) begin
                        estado                    <= S_ENCH;
                        sensor_posicao_enchimento <= 1'b1;
                    end
                end
                S_ENCH: begin
                    if (esteira) begin
                        estado                    <= S_TRANSP_CQ;
                        sensor_posicao_enchimento <= 1'b0;
                        sensor_nivel              <= 1'b0;
                    end else begin
                        sensor_nivel <= nivel_prox;
                    end
                end
                S_TRANSP_CQ: begin
                    if (chega_cq) begin
                        estado            <= S_CQ;
                        sensor_posicao_cq <= 1'b1;
                        idx               <= idx + 8'd1;
                    end
                end
                S_CQ: begin
                    if (descarte_ativo || esteira) begin
                        if (descarte_ativo) begin
                            garrafas_descartadas <= inc_sat(garrafas_descartadas);
                            if (aprovado) erro[ERR_DESCARTE_APROVADA] <= 1'b1;
                        end else if (aprovado) begin
                            garrafas_ok <= inc_sat(garrafas_ok);
                        end else begin
                            // Leaving without a pass verdict covers both "no verdict yet" and "failed".
                            erro[ERR_SAIDA_REPROVADA] <= 1'b1;
                        end
                        estado            <= S_TRANSP_ENCH;
                        sensor_posicao_cq <= 1'b0;
                        aprovado          <= 1'b0;
                        reprovado         <= 1'b0;
                    end else if (insp_prox) begin
                        aprovado  <= !reprova;
                        reprovado <= reprova;
                    end
                end
                default: estado <= S_TRANSP_ENCH;
            endcase
        end
    end

endmodule

// File: tb/tb_simulador_planta_vinho.sv
module tb_simulador_planta_vinho;

    localparam int TT = 4;
    localparam int TE = 3;
    localparam int TV = 2;
    localparam int TI = 2;
    localparam int RC = 3;

    // Where the current bottle physically is.
    localparam int ROAD1 = 0;
    localparam int FILL  = 1;
    localparam int ROAD2 = 2;
    localparam int QC    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       esteira, valvula_ativa, vedacao_ativa, descarte_ativo;
    logic       sensor_posicao_enchimento, sensor_nivel, sensor_posicao_cq;
    logic       aprovado, reprovado;
    logic [7:0] garrafas_ok, garrafas_descartadas;
    logic [2:0] erro;

    always #5 clk = ~clk;

    simulador_planta_vinho #(
        .T_TRANSPORTE(TT), .T_ENCHER(TE), .T_VEDAR(TV), .T_INSPECAO(TI), .REPROVA_CADA(RC)
    ) dut (
        .clk(clk), .reset(reset),
        .esteira(esteira), .valvula_ativa(valvula_ativa),
        .vedacao_ativa(vedacao_ativa), .descarte_ativo(descarte_ativo),
        .sensor_posicao_enchimento(sensor_posicao_enchimento),
        .sensor_nivel(sensor_nivel), .sensor_posicao_cq(sensor_posicao_cq),
        .aprovado(aprovado), .reprovado(reprovado),
        .garrafas_ok(garrafas_ok), .garrafas_descartadas(garrafas_descartadas),
        .erro(erro)
    );

    typedef struct packed {
        logic       pe;
        logic       nivel;
        logic       pcq;
        logic       apr;
        logic       rep;
        logic [7:0] ok;
        logic [7:0] desc;
        logic [2:0] err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: bottle location, travelled distance, fill/seal progress, inspection time.
    int       m_where, m_dist, m_level, m_seal, m_insp, m_idx, m_ok, m_desc;
    logic [2:0] m_err;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_where = ROAD1; m_dist = 0; m_level = 0; m_seal = 0;
        m_insp = 0; m_idx = 0; m_ok = 0; m_desc = 0; m_err = 3'b000;
    endfunction

    function automatic bit m_pass();
        return (m_level == TE) && (m_seal == TV) && !(RC != 0 && (m_idx % RC) == 0);
    endfunction

    function automatic bit m_verdict();
        return m_insp >= TI;
    endfunction

    function automatic void m_step(input bit e, input bit v, input bit s, input bit d);
        bit full, apr;
        if (v && (m_where != FILL || e)) m_err[0] = 1'b1;
        case (m_where)
            ROAD1, ROAD2: begin
                if (e) begin
                    if (m_dist == TT - 1) begin
                        m_dist = 0;
                        if (m_where == ROAD1) begin
                            m_where = FILL; m_level = 0; m_seal = 0;
                        end else begin
                            m_where = QC; m_insp = 0; m_idx = (m_idx + 1) % 256;
                        end
                    end else begin
                        m_dist++;
                    end
                end
            end
            FILL: begin
                full = (m_level == TE);
                if (v && m_level < TE) m_level++;
                if (s && full && m_seal < TV) m_seal++;
                if (e) begin
                    m_where = ROAD2; m_dist = 0;
                end
            end
            default: begin
                apr = m_verdict() && m_pass();
                if (d) begin
                    if (m_desc < 255) m_desc++;
                    if (apr) m_err[2] = 1'b1;
                    m_where = ROAD1;
                end else if (e) begin
                    if (apr) begin
                        if (m_ok < 255) m_ok++;
                    end else begin
                        m_err[1] = 1'b1;
                    end
                    m_where = ROAD1;
                end else if (m_insp < TI) begin
                    m_insp++;
                end
            end
        endcase
    endfunction

    function automatic exp_t m_out();
        exp_t x;
        x.pe    = (m_where == FILL);
        x.nivel = (m_where == FILL) && (m_level == TE);
        x.pcq   = (m_where == QC);
        x.apr   = (m_where == QC) && m_verdict() && m_pass();
        x.rep   = (m_where == QC) && m_verdict() && !m_pass();
        x.ok    = 8'(m_ok);
        x.desc  = 8'(m_desc);
        x.err   = m_err;
        return x;
    endfunction

    // Stimulus: drive one cycle of commands at the falling edge and queue the model's prediction.
    task automatic step(input bit e, input bit v, input bit s, input bit d);
        @(negedge clk);
        esteira = e; valvula_ativa = v; vedacao_ativa = s; descarte_ativo = d;
        m_step(e, v, s, d);
        q.push_back(m_out());
    endtask

    task automatic rep(input int n, input bit e, input bit v, input bit s, input bit d);
        for (int i = 0; i < n; i++) step(e, v, s, d);
    endtask

    // Wait until the monitor has consumed the last prediction.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pe"},   32'(sensor_posicao_enchimento), 0);
        chk({tag, " niv"},  32'(sensor_nivel), 0);
        chk({tag, " pcq"},  32'(sensor_posicao_cq), 0);
        chk({tag, " apr"},  32'(aprovado), 0);
        chk({tag, " rep"},  32'(reprovado), 0);
        chk({tag, " ok"},   32'(garrafas_ok), 0);
        chk({tag, " desc"}, 32'(garrafas_descartadas), 0);
        chk({tag, " erro"}, 32'(erro), 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        esteira = 0; valvula_ativa = 0; vedacao_ativa = 0; descarte_ativo = 0;
        reset = 1'b0;
        #1;
        chk_all_zero(tag);
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Good bottle: transport, fill, seal, move to QC, wait for the verdict.
    task automatic good_bottle_to_verdict();
        rep(TT, 1, 0, 0, 0);
        rep(TE, 0, 1, 0, 0);
        rep(TV, 0, 0, 1, 0);
        rep(TT + 1, 1, 0, 0, 0);
        rep(TI, 0, 0, 0, 0);
    endtask

    // Monitor: pop and compare a prediction whenever one is pending after an edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sensor_posicao_enchimento", 32'(sensor_posicao_enchimento), 32'(x.pe));
            chk("sensor_nivel",              32'(sensor_nivel),              32'(x.nivel));
            chk("sensor_posicao_cq",         32'(sensor_posicao_cq),         32'(x.pcq));
            chk("aprovado",                  32'(aprovado),                  32'(x.apr));
            chk("reprovado",                 32'(reprovado),                 32'(x.rep));
            chk("garrafas_ok",               32'(garrafas_ok),               32'(x.ok));
            chk("garrafas_descartadas",      32'(garrafas_descartadas),      32'(x.desc));
            chk("erro",                      32'(erro),                      32'(x.err));
        end
    end

    initial begin
        reset = 1'b0;
        esteira = 0; valvula_ativa = 0; vedacao_ativa = 0; descarte_ativo = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // Three motor cycles are not enough, the fourth reaches the fill station.
        rep(TT - 1, 1, 0, 0, 0);
        settle(); chk("short transport pe", 32'(sensor_posicao_enchimento), 0);
        step(1, 0, 0, 0);
        settle(); chk("transport pe", 32'(sensor_posicao_enchimento), 1);
        rep(TE, 0, 1, 0, 0);
        settle(); chk("filled nivel", 32'(sensor_nivel), 1);
        rep(TV, 0, 0, 1, 0);
        rep(TT + 1, 1, 0, 0, 0);
        settle(); chk("at qc", 32'(sensor_posicao_cq), 1);
        rep(TI, 0, 0, 0, 0);
        settle(); chk("bottle1 aprovado", 32'(aprovado), 1);
        step(1, 0, 0, 0);
        settle(); chk("bottle1 ok", 32'(garrafas_ok), 1); chk("bottle1 erro", 32'(erro), 0);

        good_bottle_to_verdict();
        step(1, 0, 0, 0);
        settle(); chk("bottle2 ok", 32'(garrafas_ok), 2);

        // Third bottle is a forced failure and gets discarded.
        good_bottle_to_verdict();
        settle(); chk("bottle3 reprovado", 32'(reprovado), 1);
        step(0, 0, 0, 1);
        settle(); chk("bottle3 desc", 32'(garrafas_descartadas), 1); chk("bottle3 ok", 32'(garrafas_ok), 2);

        // Unsealed bottle pushed out by the conveyor.
        rep(TT, 1, 0, 0, 0);
        rep(TE, 0, 1, 0, 0);
        rep(TT + 1, 1, 0, 0, 0);
        rep(TI, 0, 0, 0, 0);
        settle(); chk("unsealed reprovado", 32'(reprovado), 1);
        step(1, 0, 0, 0);
        settle(); chk("unsealed erro1", 32'(erro[1]), 1); chk("unsealed ok", 32'(garrafas_ok), 2);

        // Valve opened while moving, then an approved bottle discarded.
        step(1, 1, 0, 0);
        settle(); chk("valve in transport erro0", 32'(erro[0]), 1);
        rep(TT - 1, 1, 0, 0, 0);
        rep(TE, 0, 1, 0, 0);
        rep(TV, 0, 0, 1, 0);
        rep(TT + 1, 1, 0, 0, 0);
        rep(TI, 0, 0, 0, 0);
        settle(); chk("bottle5 aprovado", 32'(aprovado), 1);
        step(0, 0, 0, 1);
        settle(); chk("discard approved erro2", 32'(erro[2]), 1); chk("bottle5 desc", 32'(garrafas_descartadas), 2);

        // Discard and conveyor together: the discard is what counts.
        rep(TT, 1, 0, 0, 0);
        rep(TT + 1, 1, 0, 0, 0);
        step(1, 0, 0, 1);
        settle(); chk("both desc", 32'(garrafas_descartadas), 3); chk("both ok", 32'(garrafas_ok), 2);

        // Reset in the middle of filling, then a full transport is needed again.
        rep(TT, 1, 0, 0, 0);
        rep(2, 0, 1, 0, 0);
        settle(); chk("pre-reset pe", 32'(sensor_posicao_enchimento), 1);
        async_reset("midreset");
        rep(TT - 1, 1, 0, 0, 0);
        settle(); chk("post-reset short pe", 32'(sensor_posicao_enchimento), 0);
        step(1, 0, 0, 0);
        settle(); chk("post-reset pe", 32'(sensor_posicao_enchimento), 1);

        // Random command mix against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6);
        end
        settle();

        // Discard counter saturation and bottle-index wrap.
        async_reset("satreset");
        for (int b = 0; b < 260; b++) begin
            rep(TT, 1, 0, 0, 0);
            rep(TT + 1, 1, 0, 0, 0);
            step(0, 0, 0, 1);
        end
        settle();
        chk("sat desc", 32'(garrafas_descartadas), 255);
        chk("sat ok", 32'(garrafas_ok), 0);
        chk("sat erro", 32'(erro), 0);

        chk("scoreboard drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
